uart8_transmitter: RTL and testbench

- 8-bit UART transmitter; the transmit counterpart of the team's 8-bit UART receiver.
- Serialises one parallel byte per frame onto txOut: one start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits.
- clk is the system clock divided down to OVERSAMPLE x baud, the same tick the receiver samples on. Each serial bit is held for exactly OVERSAMPLE clk ticks.

---
 rtl/uart8_transmitter.sv | 186 ++++++++++++++++++
 tb/tb_uart8_transmitter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart8_transmitter.sv
// 8-bit UART transmitter.
// Sends one byte per frame: a start bit, 8 data bits LSB first, an optional
// parity bit and 1 or 2 stop bits. Each serial bit lasts OVERSAMPLE clk ticks.
// All outputs are registered and reflect the state held during the previous
// cycle. As a result the line follows the accepting edge by one cycle, and
// done rises one cycle after the last stop tick.
//
// Handshake: start is a request qualified by en. It is taken only when the
// FSM is IDLE, and txData is captured on that same edge. A request made while
// busy is dropped and causes no side effect. It is not queued.
module uart8_transmitter #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] txData,
  output logic       txOut,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tick;
  logic [TW-1:0] w_tick_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_parity;
  logic          w_parity_nxt;
  logic          r_fin;
  logic          w_fin_nxt;
  logic          w_tick_last;
  logic          w_tx_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;

  // Final tick of the serial bit currently on the line
  assign w_tick_last = (r_tick == TICK_LAST);

  // Next-state, counters and registered-output values, all derived from the current state
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_fin_nxt     = 1'b0;
    w_tx_nxt      = 1'b1;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = r_fin;

    if (!en) begin
      // Abort: park in IDLE with the line high and suppress any pending done
      w_state_nxt   = S_IDLE;
      w_tick_nxt    = '0;
      w_bit_idx_nxt = 3'd0;
      w_done_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_shift_nxt   = txData;
            w_parity_nxt  = (PARITY == 1) ? ~(^txData) : (^txData);
            w_tick_nxt    = '0;
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = S_START;
          end
        end

        S_START: begin
          w_tx_nxt   = 1'b0;
          w_busy_nxt = 1'b1;
          if (w_tick_last) begin
            w_tick_nxt    = '0;
            w_bit_idx_nxt = 3'd0;
            w_state_nxt   = S_DATA;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end

        S_DATA: begin
          w_tx_nxt   = r_shift[0];
          w_busy_nxt = 1'b1;
          if (w_tick_last) begin
            w_tick_nxt    = '0;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            // The 3-bit index wraps 7 -> 0 as the last data bit finishes
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end

        S_PARITY: begin
          w_tx_nxt   = r_parity;
          w_busy_nxt = 1'b1;
          if (w_tick_last) begin
            w_tick_nxt  = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end

        S_STOP: begin
          // The bit index, already back at 0, counts stop bits here
          w_tx_nxt   = 1'b1;
          w_busy_nxt = 1'b1;
          if (w_tick_last) begin
            w_tick_nxt = '0;
            if (r_bit_idx == STOP_LAST) begin
              w_bit_idx_nxt = 3'd0;
              w_fin_nxt     = 1'b1;
              w_state_nxt   = S_IDLE;
            end else begin
              w_bit_idx_nxt = r_bit_idx + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end

        default: begin
          w_state_nxt   = S_IDLE;
          w_tick_nxt    = '0;
          w_bit_idx_nxt = 3'd0;
        end
      endcase
    end
  end

  // FSM state, counters and the captured frame contents
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_parity  <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_fin     <= w_fin_nxt;
    end
  end

  // Registered outputs, so that no input reaches a pin through combinational logic
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      txOut <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      txOut <= w_tx_nxt;
      busy  <= w_busy_nxt;
      done  <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_uart8_transmitter.sv
// Testbench for uart8_transmitter.
// Four instances with different OVERSAMPLE / PARITY / STOP_BITS settings
// share one stimulus stream. Each instance has its own frame-timeline model,
// and instance 0 also feeds a mid-bit sampling receiver with a byte scoreboard.
module tb_uart8_transmitter;

  localparam int N_DUT = 4;

  logic             clk = 1'b0;
  logic             rstN;
  logic             en;
  logic             start;
  logic [7:0]       txData;
  logic [N_DUT-1:0] w_tx;
  logic [N_DUT-1:0] w_busy;
  logic [N_DUT-1:0] w_done;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt [N_DUT];
  logic       lb_on = 1'b0;
  logic [7:0] exp_q[$];
  int         rx_seen = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Whole frame as a bit vector: start, data LSB first, optional parity, then ones
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input int par);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par == 1) f[9] = ~(^d);
    else if (par == 2) f[9] = ^d;
    return f;
  endfunction

  // ---------------- DUTs and reference models ----------------
  for (genvar g = 0; g < N_DUT; g++) begin : g_inst
    localparam int OS  = (g == 3) ? 4 : 16;
    localparam int PAR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SB  = (g == 3) ? 2 : 1;
    localparam int L   = (9 + ((PAR != 0) ? 1 : 0) + SB) * OS;

    uart8_transmitter #(
      .OVERSAMPLE(OS),
      .PARITY    (PAR),
      .STOP_BITS (SB)
    ) u_dut (
      .clk   (clk),
      .rstN  (rstN),
      .en    (en),
      .start (start),
      .txData(txData),
      .txOut (w_tx[g]),
      .busy  (w_busy[g]),
      .done  (w_done[g])
    );

    // age = edges since the accepting edge; the frame occupies ages 1..L
    int          age      = -1;
    logic [11:0] fbits    = '1;
    logic        e_tx     = 1'b1;
    logic        e_busy   = 1'b0;
    logic        e_done   = 1'b0;
    bit          in_frame = 1'b0;
    int          n_done   = 0;

    always @(posedge clk or negedge rstN) begin
      if (!rstN || !en) begin
        age    = -1;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
      end else begin
        if (age >= 0) age++;
        in_frame = (age >= 1) && (age <= L);
        e_busy   = in_frame;
        e_tx     = in_frame ? fbits[(age - 1) / OS] : 1'b1;
        e_done   = (age == L + 1);
        if (age > L) age = -1;
        if (!in_frame && start) begin
          fbits = frame_bits(txData, PAR);
          age   = 0;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("tx%0d", g),   32'(w_tx[g]),   32'(e_tx));
      check($sformatf("busy%0d", g), 32'(w_busy[g]), 32'(e_busy));
      check($sformatf("done%0d", g), 32'(w_done[g]), 32'(e_done));
      if (w_done[g]) n_done++;
    end

    assign done_cnt[g] = n_done;
  end

  // ---------------- loopback receiver on instance 0 (16x, 8N1) ----------------
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'd0;
  logic [7:0] rx_exp;

  always @(negedge clk) begin
    if (!lb_on) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (w_tx[0] == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 24 && rx_cnt <= 136 && (rx_cnt % 16) == 8)
        rx_byte = {w_tx[0], rx_byte[7:1]};
      if (rx_cnt == 152) begin
        check("lb_stop", 32'(w_tx[0]), 32'd1);
        if (exp_q.size() == 0) begin
          check("lb_unexpected_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          rx_exp = exp_q.pop_front();
          check("lb_byte", 32'(rx_byte), 32'(rx_exp));
        end
        rx_seen++;
        rx_act = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    txData = v;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int d0;
  int b;

  initial begin
    rstN   = 1'b1;
    en     = 1'b0;
    start  = 1'b0;
    txData = 8'd0;
    #1 rstN = 1'b0;
    tick(3);
    rstN = 1'b0;
    tick(1);
    rstN = 1'b1;
    tick(2);
    en = 1'b1;
    tick(1);

    // Single frames: 8N1 pattern, then parity cases
    d0 = done_cnt[0];
    send_byte(8'hA5);
    tick(200);
    check("a5_done_count", 32'(done_cnt[0] - d0), 32'd1);
    send_byte(8'h07);
    tick(200);

    // start held high across two frames, data changed after the first acceptance
    d0     = done_cnt[0];
    txData = 8'h55;
    start  = 1'b1;
    tick(1);
    txData = 8'h0F;
    tick(199);
    start  = 1'b0;
    tick(400);
    check("held_done_count", 32'(done_cnt[0] - d0), 32'd2);

    // start while busy is ignored
    d0 = done_cnt[0];
    send_byte(8'hC3);
    tick(39);
    send_byte(8'($urandom_range(0, 255)));
    tick(250);
    check("busy_start_done_count", 32'(done_cnt[0] - d0), 32'd1);

    // en dropped mid-frame, then a fresh frame
    d0 = done_cnt[0];
    send_byte(8'($urandom_range(0, 255)));
    tick(69);
    en = 1'b0;
    tick(1);
    check("abort_tx", 32'(w_tx[0]), 32'd1);
    check("abort_busy", 32'(w_busy[0]), 32'd0);
    tick(2);
    en = 1'b1;
    send_byte(8'h3C);
    tick(200);
    check("abort_done_count", 32'(done_cnt[0] - d0), 32'd1);

    // Asynchronous reset in the middle of a data bit
    send_byte(8'h00);
    tick(50);
    #2 rstN = 1'b0;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("arst_tx%0d", i),   32'(w_tx[i]),   32'd1);
      check($sformatf("arst_busy%0d", i), 32'(w_busy[i]), 32'd0);
      check($sformatf("arst_done%0d", i), 32'(w_done[i]), 32'd0);
    end
    @(posedge clk);
    #1 rstN = 1'b1;
    tick(2);

    // Random traffic with occasional enable drops
    repeat (3000) begin
      txData = 8'($urandom_range(0, 255));
      start  = ($urandom_range(0, 19) == 0);
      en     = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    en    = 1'b1;
    start = 1'b0;
    tick(200);

    // Loopback of every byte value, restarting in the done cycle
    lb_on = 1'b1;
    tick(2);
    for (int v = 0; v < 256; v++) begin
      exp_q.push_back(8'(v));
      send_byte(8'(v));
      b = 0;
      while (!w_done[0] && b < 400) begin
        tick(1);
        b++;
      end
      check("lb_frame_timeout", 32'(b < 400), 32'd1);
    end
    tick(20);
    lb_on = 1'b0;
    check("lb_rx_count", 32'(rx_seen), 32'd256);
    check("lb_queue_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
